// File: rtl/booth_mult_ctrl.sv
// ---------------------------------------------------------------------------
// booth_mult_ctrl
//   Sequential radix-2 Booth multiplier controller, signed N x N -> 2N.
//   Holds the A/Q/Q_1/M registers, the iteration counter and the control FSM,
//   and borrows one external N-bit adder for the add/subtract step of each
//   iteration. One multiply is in flight at a time.
//
// Handshake: a request is accepted on a rising edge where start=1 and the FSM
//   is IDLE; operands are captured on that edge only. busy stays high from
//   that edge until the FSM returns to IDLE. done pulses for exactly one cycle
//   when product becomes valid; product then holds until the next completion.
//   start seen while busy is ignored.
//
// Ports
//   clk          in   1    clock, rising edge
//   rst          in   1    asynchronous, active-high reset
//   start        in   1    multiply request (sampled only in IDLE)
//   multiplicand in   N    signed M, captured on accepted start
//   multiplier   in   N    signed Q, captured on accepted start
//   add_x0       out  N    adder operand 0 (A while calculating)
//   add_x1       out  N    adder operand 1 (M, ~M or 0)
//   add_cin      out  1    adder carry-in
//   add_y        in   N    adder sum
//   add_extend   in   1    true sign of the N+1-bit adder sum
//   busy         out  1    FSM not in IDLE
//   done         out  1    one-cycle completion pulse
//   product      out  2N   signed product
// ---------------------------------------------------------------------------
module booth_mult_ctrl #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [N-1:0]   add_x0,
    output logic [N-1:0]   add_x1,
    output logic           add_cin,
    input  logic [N-1:0]   add_y,
    input  logic           add_extend,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     q_reg;
    logic [N-1:0]     m_reg;
    logic             q_1;
    logic [CW-1:0]    count;
    logic [2*N-1:0]   product_reg;

    // Next A/Q after the arithmetic right shift. The shift-in bit is the
    // adder's true N+1-bit sign so that A+M / A-M overflow (including
    // M = -2^(N-1)) shifts in the correct sign.
    logic [N-1:0]     a_next;
    logic [N-1:0]     q_next;

    assign a_next = {add_extend, add_y[N-1:1]};
    assign q_next = {add_y[0], q_reg[N-1:1]};

    // Adder operand selection; adder is idle (all zero) outside CALC.
    always_comb begin
        add_x0  = '0;
        add_x1  = '0;
        add_cin = 1'b0;
        if (state == CALC) begin
            add_x0 = a_reg;
            case ({q_reg[0], q_1})
                2'b01: begin
                    add_x1 = m_reg;
                end
                2'b10: begin
                    add_x1  = ~m_reg;
                    add_cin = 1'b1;
                end
                default: begin
                    add_x1 = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            q_1         <= 1'b0;
            count       <= '0;
            product_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= '0;
                        q_reg <= multiplier;
                        q_1   <= 1'b0;
                        m_reg <= multiplicand;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_1   <= q_reg[0];
                    count <= count + 1'b1;
                    if (count == CW'(N - 1)) begin
                        product_reg <= {a_next, q_next};
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = product_reg;

endmodule

// File: tb/tb_booth_mult_ctrl.sv
module tb_booth_mult_ctrl;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic [N-1:0]   add_x0;
    logic [N-1:0]   add_x1;
    logic           add_cin;
    logic [N-1:0]   add_y;
    logic           add_extend;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int checks;
    int failures;
    int done_cnt;

    booth_mult_ctrl #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_x0       (add_x0),
        .add_x1       (add_x1),
        .add_cin      (add_cin),
        .add_y        (add_y),
        .add_extend   (add_extend),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- external adder model ----------------
    // N+1-bit signed sum of the two operands plus carry; the top bit is the
    // true sign of the result.
    logic [N:0] sum_ext;
    always_comb begin
        sum_ext    = {add_x0[N-1], add_x0} + {add_x1[N-1], add_x1} + {{N{1'b0}}, add_cin};
        add_y      = sum_ext[N-1:0];
        add_extend = sum_ext[N];
    end

    // done pulses observed away from the active edge
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // ---------------- scoreboard helpers ----------------
    logic [2*N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mult(input logic [N-1:0] a, input logic [N-1:0] b);
        int sa;
        int sb;
        int p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        p  = sa * sb;
        return p[2*N-1:0];
    endfunction

    // Called at a negedge; leaves the bench at the negedge where done was seen.
    task automatic do_mult(input logic [N-1:0] a, input logic [N-1:0] b,
                           output logic [2*N-1:0] p, output int lat, output int busy_cycles);
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start       = 1'b0;
        lat         = 0;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
        end
        p = product;
    endtask

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [2*N-1:0] p;
        logic [N-1:0]   ra;
        logic [N-1:0]   rb;
        int lat;
        int bc;
        int d0;

        checks   = 0;
        failures = 0;
        done_cnt = 0;

        vecs[0] = '{8'd3,    8'd5,    16'h000F};
        vecs[1] = '{8'hFD,   8'd5,    16'hFFF1};
        vecs[2] = '{8'd5,    8'hFD,   16'hFFF1};
        vecs[3] = '{8'h80,   8'h80,   16'h4000};
        vecs[4] = '{8'h80,   8'h7F,   16'hC080};
        vecs[5] = '{8'h7F,   8'h7F,   16'h3F01};
        vecs[6] = '{8'h00,   8'h55,   16'h0000};
        vecs[7] = '{8'hAB,   8'h00,   16'h0000};
        vecs[8] = '{8'hFF,   8'hFF,   16'h0001};
        vecs[9] = '{8'h80,   8'h01,   16'hFF80};

        // ---------------- reset ----------------
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy",    32'(busy),    32'd0);
        check("reset_done",    32'(done),    32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_add_x0",  32'(add_x0),  32'd0);
        check("reset_add_x1",  32'(add_x1),  32'd0);
        check("reset_add_cin", 32'(add_cin), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 10; i++) begin
            do_mult(vecs[i].a, vecs[i].b, p, lat, bc);
            check($sformatf("vec%0d_product", i), 32'(p),   32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(N));
            check($sformatf("vec%0d_busy",    i), 32'(bc),  32'(N + 1));
            @(negedge clk);
            check($sformatf("vec%0d_idle_busy", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_idle_done", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(product), 32'(vecs[i].exp));
        end

        // ---------------- start hammered while busy ----------------
        d0           = done_cnt;
        start        = 1'b1;
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        @(negedge clk);
        lat = 0;
        while (!done && lat < 50) begin
            multiplicand = 8'($urandom_range(0, 255));
            multiplier   = 8'($urandom_range(0, 255));
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("hammer_product", 32'(product), 32'h003F);
        check("hammer_latency", 32'(lat), 32'(N));
        repeat (4) @(negedge clk);
        check("hammer_done_count", 32'(done_cnt - d0), 32'd1);
        check("hammer_idle", 32'(busy), 32'd0);

        // ---------------- reset in the middle of CALC ----------------
        start        = 1'b1;
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        check("midrst_busy",    32'(busy),    32'd0);
        check("midrst_done",    32'(done),    32'd0);
        check("midrst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        check("midrst_product_held", 32'(product), 32'd0);
        do_mult(8'd2, 8'd2, p, lat, bc);
        check("after_rst_product", 32'(p),   32'h0004);
        check("after_rst_latency", 32'(lat), 32'(N));
        @(negedge clk);

        // ---------------- random vs reference model ----------------
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            exp_q.push_back(ref_mult(ra, rb));
            do_mult(ra, rb, p, lat, bc);
            if (lat >= 50) begin
                check($sformatf("rand%0d_timeout", i), 32'(lat), 32'(N));
            end
            check($sformatf("rand%0d_%0h_x_%0h", i, ra, rb), 32'(p), 32'(exp_q.pop_front()));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
